// File: rtl/radar_sync_pkg.sv
// Shared types and default geometry for the radar front-end timing controller
// and the target-data fetch block.
package radar_sync_pkg;

  localparam int DEF_ACP_W       = 12;
  localparam int DEF_ACP_PER_REV = 4096;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ARP = 2'd1,
    RUN      = 2'd2,
    SWEEP    = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/sig_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, followed by a history
// flop and registered single-cycle rise/fall pulses.
module sig_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_sig,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // NOTE: every signal written here is given a value on every path, so no latch is inferred.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_sig};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & hist_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/radar_sync_ctrl.sv
// Antenna timing controller: azimuth tracking from ARP/ACP, per-azimuth
// fetch handshake, trigger-driven sweep window and sticky fault flags.
module radar_sync_ctrl
  import radar_sync_pkg::*;
#(
  parameter int ACP_W       = DEF_ACP_W,
  parameter int ACP_PER_REV = DEF_ACP_PER_REV,
  parameter int SWEEP_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               arp_in,
  input  logic               acp_in,
  input  logic               trig_in,
  input  logic [SWEEP_W-1:0] sweep_len,
  input  logic               clr_err,
  input  logic               fetch_ack,
  output logic               fetch_req,
  output logic [ACP_W-1:0]   fetch_az,
  output logic [ACP_W-1:0]   az_cnt,
  output logic               synced,
  output logic               sweep_start,
  output logic               sweep_active,
  output logic [ACP_W-1:0]   sweep_az,
  output logic               arp_err,
  output logic               trig_miss,
  output logic               fetch_ovr
);

  localparam logic [ACP_W-1:0] AZ_MAX = ACP_W'(ACP_PER_REV - 1);

  logic       arp_rise, acp_rise, trig_rise;
  logic [5:0] unused_sync_fall;

  sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_arp_sync (
    .clk(clk), .rst(rst), .async_sig(arp_in),
    .sync(unused_sync_fall[0]), .rise(arp_rise), .fall(unused_sync_fall[1])
  );
  sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_acp_sync (
    .clk(clk), .rst(rst), .async_sig(acp_in),
    .sync(unused_sync_fall[2]), .rise(acp_rise), .fall(unused_sync_fall[3])
  );
  sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
    .clk(clk), .rst(rst), .async_sig(trig_in),
    .sync(unused_sync_fall[4]), .rise(trig_rise), .fall(unused_sync_fall[5])
  );

  ctrl_state_e        state_q, state_d;
  logic [ACP_W-1:0]   az_cnt_q, az_cnt_d, fetch_az_q, fetch_az_d, sweep_az_q, sweep_az_d;
  logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic               synced_q, synced_d, fetch_req_q, fetch_req_d;
  logic               sweep_start_q, sweep_start_d, sweep_active_q, sweep_active_d;
  logic               arp_err_q, arp_err_d, trig_miss_q, trig_miss_d, fetch_ovr_q, fetch_ovr_d;
  logic               az_chg, arp_err_set, trig_miss_set, fetch_ovr_set;
  logic [ACP_W-1:0]   az_next;

  always_comb begin
    state_d        = state_q;
    az_cnt_d       = az_cnt_q;
    synced_d       = synced_q;
    fetch_req_d    = fetch_req_q;
    fetch_az_d     = fetch_az_q;
    sweep_start_d  = 1'b0;
    sweep_active_d = sweep_active_q;
    sweep_az_d     = sweep_az_q;
    sweep_cnt_d    = sweep_cnt_q;
    az_chg         = 1'b0;
    az_next        = az_cnt_q;
    arp_err_set    = 1'b0;
    trig_miss_set  = 1'b0;
    fetch_ovr_set  = 1'b0;

    if (!en) begin
      state_d        = IDLE;
      synced_d       = 1'b0;
      sweep_active_d = 1'b0;
      fetch_req_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_ARP;
        WAIT_ARP: begin
          if (arp_rise) begin
            az_chg   = 1'b1;
            az_next  = '0;
            synced_d = 1'b1;
            state_d  = RUN;
          end
        end
        RUN, SWEEP: begin
          // ARP takes priority over a coincident ACP, which is then dropped.
          if (arp_rise) begin
            az_chg      = 1'b1;
            az_next     = '0;
            arp_err_set = (az_cnt_q != AZ_MAX);
          end else if (acp_rise) begin
            az_chg  = 1'b1;
            az_next = (az_cnt_q == AZ_MAX) ? '0 : az_cnt_q + 1'b1;
          end
          if (state_q == RUN) begin
            if (trig_rise) begin
              sweep_start_d  = 1'b1;
              sweep_active_d = 1'b1;
              sweep_az_d     = az_cnt_q;
              sweep_cnt_d    = (sweep_len == '0) ? SWEEP_W'(1) : sweep_len;
              state_d        = SWEEP;
            end
          end else begin
            trig_miss_set = trig_rise;
            if (sweep_cnt_q <= SWEEP_W'(1)) begin
              sweep_active_d = 1'b0;
              state_d        = RUN;
            end else begin
              sweep_cnt_d = sweep_cnt_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // A coincident ack retires the old request; the new azimuth re-raises it.
      if (az_chg) begin
        az_cnt_d      = az_next;
        fetch_az_d    = az_next;
        fetch_req_d   = 1'b1;
        fetch_ovr_set = fetch_req_q & ~fetch_ack;
      end else if (fetch_req_q && fetch_ack) begin
        fetch_req_d = 1'b0;
      end
    end

    arp_err_d   = (arp_err_q   & ~clr_err) | arp_err_set;
    trig_miss_d = (trig_miss_q & ~clr_err) | trig_miss_set;
    fetch_ovr_d = (fetch_ovr_q & ~clr_err) | fetch_ovr_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      az_cnt_q       <= '0;
      synced_q       <= 1'b0;
      fetch_req_q    <= 1'b0;
      fetch_az_q     <= '0;
      sweep_start_q  <= 1'b0;
      sweep_active_q <= 1'b0;
      sweep_az_q     <= '0;
      sweep_cnt_q    <= '0;
      arp_err_q      <= 1'b0;
      trig_miss_q    <= 1'b0;
      fetch_ovr_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      az_cnt_q       <= az_cnt_d;
      synced_q       <= synced_d;
      fetch_req_q    <= fetch_req_d;
      fetch_az_q     <= fetch_az_d;
      sweep_start_q  <= sweep_start_d;
      sweep_active_q <= sweep_active_d;
      sweep_az_q     <= sweep_az_d;
      sweep_cnt_q    <= sweep_cnt_d;
      arp_err_q      <= arp_err_d;
      trig_miss_q    <= trig_miss_d;
      fetch_ovr_q    <= fetch_ovr_d;
    end
  end

  assign fetch_req    = fetch_req_q;
  assign fetch_az     = fetch_az_q;
  assign az_cnt       = az_cnt_q;
  assign synced       = synced_q;
  assign sweep_start  = sweep_start_q;
  assign sweep_active = sweep_active_q;
  assign sweep_az     = sweep_az_q;
  assign arp_err      = arp_err_q;
  assign trig_miss    = trig_miss_q;
  assign fetch_ovr    = fetch_ovr_q;

endmodule

// File: tb/tb_radar_sync_ctrl.sv
// Self-checking bench for radar_sync_ctrl: event table, hand-written corner
// sequences, and random events against an event-level reference model.
module tb_radar_sync_ctrl;

  localparam int ACP_W       = 12;
  localparam int PER         = 8;
  localparam int SWEEP_W     = 16;
  localparam int SYNC_STAGES = 2;

  logic               clk = 1'b0;
  logic               rst, en, arp_in, acp_in, trig_in, clr_err, fetch_ack;
  logic [SWEEP_W-1:0] sweep_len;
  logic               fetch_req, synced, sweep_start, sweep_active;
  logic               arp_err, trig_miss, fetch_ovr;
  logic [ACP_W-1:0]   fetch_az, az_cnt, sweep_az;

  radar_sync_ctrl #(
    .ACP_W(ACP_W), .ACP_PER_REV(PER), .SWEEP_W(SWEEP_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .arp_in(arp_in), .acp_in(acp_in), .trig_in(trig_in),
    .sweep_len(sweep_len), .clr_err(clr_err), .fetch_ack(fetch_ack),
    .fetch_req(fetch_req), .fetch_az(fetch_az), .az_cnt(az_cnt), .synced(synced),
    .sweep_start(sweep_start), .sweep_active(sweep_active), .sweep_az(sweep_az),
    .arp_err(arp_err), .trig_miss(trig_miss), .fetch_ovr(fetch_ovr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef enum {OP_ACP, OP_ARP, OP_ACK, OP_CLR} op_e;
  typedef struct {
    op_e op;
    bit  ack_after;
    int  exp_az;
    bit  exp_req;
    bit  exp_arp_err;
    bit  exp_ovr;
  } vec_t;

  vec_t vecs[$];

  // Event-level reference model state.
  int m_az, m_faz;
  bit m_req, m_arp_err, m_ovr, m_miss;

  function automatic vec_t mk(op_e op, bit ack, int az, bit req, bit err, bit ovr);
    vec_t v;
    v.op = op; v.ack_after = ack; v.exp_az = az;
    v.exp_req = req; v.exp_arp_err = err; v.exp_ovr = ovr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {21'd0, fetch_req, fetch_az, az_cnt, synced, sweep_start, sweep_active,
            sweep_az, arp_err, trig_miss, fetch_ovr};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_in(input bit arp, input bit acp, input bit trig);
    arp_in = arp; acp_in = acp; trig_in = trig;
    step(); step();
    arp_in = 1'b0; acp_in = 1'b0; trig_in = 1'b0;
    repeat (5) step();
  endtask

  task automatic do_ack();
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
  endtask

  task automatic do_clr();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  // Drives one trigger (plus an optional second one) and measures the window.
  task automatic run_sweep(input int len, input int second_at, output int starts,
                           output int actives, output int start_idx, output int first_act);
    starts = 0; actives = 0; start_idx = -1; first_act = -1;
    sweep_len = SWEEP_W'(len);
    for (int i = 0; i < len + 14; i++) begin
      trig_in = (i < 2) || (second_at >= 0 && i >= second_at && i < second_at + 2);
      step();
      if (sweep_start) begin
        starts++;
        if (start_idx < 0) start_idx = i;
      end
      if (sweep_active) begin
        actives++;
        if (first_act < 0) first_act = i;
      end
    end
    trig_in = 1'b0;
  endtask

  task automatic model_az_change(input int new_az);
    if (m_req) m_ovr = 1'b1;
    m_az  = new_az;
    m_faz = new_az;
    m_req = 1'b1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " az_cnt"},    az_cnt,    m_az);
    check({tag, " fetch_az"},  fetch_az,  m_faz);
    check({tag, " fetch_req"}, fetch_req, m_req);
    check({tag, " arp_err"},   arp_err,   m_arp_err);
    check({tag, " fetch_ovr"}, fetch_ovr, m_ovr);
    check({tag, " trig_miss"}, trig_miss, m_miss);
    check({tag, " synced"},    synced,    1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int starts, actives, sidx, fact, len;

    rst = 1'b1; en = 1'b0; arp_in = 1'b0; acp_in = 1'b0; trig_in = 1'b0;
    clr_err = 1'b0; fetch_ack = 1'b0; sweep_len = '0;

    // Event table: full rotation, short rotation, clear, then fetch overflow.
    for (int k = 1; k < PER; k++) vecs.push_back(mk(OP_ACP, 1, k, 1, 0, 0));
    vecs.push_back(mk(OP_ARP, 1, 0, 1, 0, 0));
    for (int k = 1; k <= 5; k++) vecs.push_back(mk(OP_ACP, 1, k, 1, 0, 0));
    vecs.push_back(mk(OP_ARP, 1, 0, 1, 1, 0));
    vecs.push_back(mk(OP_CLR, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 3; k++) vecs.push_back(mk(OP_ACP, 1, k, 1, 0, 0));
    vecs.push_back(mk(OP_ACP, 0, 4, 1, 0, 0));
    vecs.push_back(mk(OP_ACP, 0, 5, 1, 0, 1));
    vecs.push_back(mk(OP_ACK, 0, 5, 0, 0, 1));
    vecs.push_back(mk(OP_CLR, 0, 5, 0, 0, 0));

    #3;
    check("reset outputs", all_outputs(), 64'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    check("idle outputs en=0", all_outputs(), 64'd0);

    en = 1'b1;
    repeat (2) step();

    // First ARP: synced must appear exactly at the 4th sampling edge.
    arp_in = 1'b1;
    step(); step();
    arp_in = 1'b0;
    step();
    check("synced before 4th edge", synced, 0);
    step();
    check("synced at 4th edge", synced, 1);
    check("first arp az_cnt", az_cnt, 0);
    check("first arp fetch_req", fetch_req, 1);
    check("first arp fetch_az", fetch_az, 0);
    repeat (3) step();
    do_ack();
    check("first arp ack", fetch_req, 0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      case (vecs[i].op)
        OP_ACP: pulse_in(0, 1, 0);
        OP_ARP: pulse_in(1, 0, 0);
        OP_ACK: do_ack();
        OP_CLR: do_clr();
        default: ;
      endcase
      check({tag, " az_cnt"},    az_cnt,    vecs[i].exp_az);
      check({tag, " fetch_az"},  fetch_az,  vecs[i].exp_az);
      check({tag, " fetch_req"}, fetch_req, vecs[i].exp_req);
      check({tag, " arp_err"},   arp_err,   vecs[i].exp_arp_err);
      check({tag, " fetch_ovr"}, fetch_ovr, vecs[i].exp_ovr);
      if (vecs[i].ack_after) begin
        do_ack();
        check({tag, " ack clears req"}, fetch_req, 0);
      end
    end

    // ARP and ACP in the same sample, starting from az 5.
    pulse_in(1, 1, 0);
    check("arp+acp az_cnt", az_cnt, 0);
    check("arp+acp fetch_req", fetch_req, 1);
    check("arp+acp fetch_az", fetch_az, 0);
    check("arp+acp arp_err", arp_err, 1);
    do_ack();
    do_clr();
    check("arp_err cleared", arp_err, 0);

    // Azimuth change coinciding with ack: seamless re-request, no overflow.
    pulse_in(0, 1, 0);
    check("pending req before coincident ack", fetch_req, 1);
    acp_in = 1'b1;
    step(); step();
    acp_in = 1'b0;
    step();
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
    check("coincident ack az_cnt", az_cnt, 2);
    check("coincident ack fetch_req", fetch_req, 1);
    check("coincident ack fetch_az", fetch_az, 2);
    check("coincident ack fetch_ovr", fetch_ovr, 0);
    repeat (3) step();
    do_ack();
    pulse_in(0, 1, 0); do_ack();
    pulse_in(0, 1, 0); do_ack();
    check("az before sweep", az_cnt, 4);

    // Sweep of 10 with a second trigger 3 cycles after the start.
    run_sweep(10, 6, starts, actives, sidx, fact);
    check("sweep10 starts", starts, 1);
    check("sweep10 active cycles", actives, 10);
    check("sweep10 start latency", sidx, 3);
    check("sweep10 active with start", fact, sidx);
    check("sweep10 sweep_az", sweep_az, 4);
    check("sweep10 trig_miss", trig_miss, 1);
    do_clr();
    check("trig_miss cleared", trig_miss, 0);

    run_sweep(0, -1, starts, actives, sidx, fact);
    check("sweep0 starts", starts, 1);
    check("sweep0 active cycles", actives, 1);
    check("sweep0 trig_miss", trig_miss, 0);

    run_sweep(5, 5, starts, actives, sidx, fact);
    check("last-cycle trig starts", starts, 1);
    check("last-cycle trig active", actives, 5);
    check("last-cycle trig_miss", trig_miss, 1);
    do_clr();

    run_sweep(5, 6, starts, actives, sidx, fact);
    check("after-window trig starts", starts, 2);
    check("after-window trig active", actives, 10);
    check("after-window trig_miss", trig_miss, 0);

    // en dropped in the 5th active cycle with a fetch pending.
    pulse_in(0, 1, 0);
    sweep_len = SWEEP_W'(20);
    trig_in = 1'b1;
    step(); step();
    trig_in = 1'b0;
    step(); step();
    check("en-drop sweep_start", sweep_start, 1);
    repeat (4) step();
    check("en-drop active before", sweep_active, 1);
    en = 1'b0;
    step();
    check("en-drop sweep_active", sweep_active, 0);
    check("en-drop fetch_req", fetch_req, 0);
    check("en-drop synced", synced, 0);
    check("en-drop az held", az_cnt, 5);

    en = 1'b1;
    repeat (2) step();
    pulse_in(1, 0, 0);
    check("resync az_cnt", az_cnt, 0);
    check("resync synced", synced, 1);
    check("resync no arp_err", arp_err, 0);

    // Asynchronous reset in the middle of a sweep with a fetch pending.
    trig_in = 1'b1;
    step(); step();
    trig_in = 1'b0;
    repeat (4) step();
    check("pre-reset sweep_active", sweep_active, 1);
    check("pre-reset fetch_req", fetch_req, 1);
    #2 rst = 1'b1;
    #1 check("async reset outputs", all_outputs(), 64'd0);
    step();
    rst = 1'b0;
    repeat (3) step();

    // Random events against the event-level model.
    pulse_in(1, 0, 0);
    m_az = 0; m_faz = 0; m_req = 1'b1; m_arp_err = 1'b0; m_ovr = 1'b0; m_miss = 1'b0;
    check_model("rand init");
    for (int e = 0; e < 40; e++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        pulse_in(0, 1, 0);
        model_az_change((m_az + 1) % PER);
      end else if (r == 5) begin
        pulse_in(1, 0, 0);
        if (m_az != PER - 1) m_arp_err = 1'b1;
        model_az_change(0);
      end else if (r < 8) begin
        do_ack();
        m_req = 1'b0;
      end else if (r == 8) begin
        len = $urandom_range(0, 12);
        run_sweep(len, -1, starts, actives, sidx, fact);
        check($sformatf("rand%0d sweep starts", e), starts, 1);
        check($sformatf("rand%0d sweep active", e), actives, (len == 0) ? 1 : len);
        check($sformatf("rand%0d sweep_az", e), sweep_az, m_az);
      end else begin
        do_clr();
        m_arp_err = 1'b0; m_ovr = 1'b0; m_miss = 1'b0;
      end
      check_model($sformatf("rand%0d", e));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/radar_sync_ctrl.md
Name: radar_sync_ctrl

Overview:
Front-end timing controller for the radar simulator. It resynchronises the antenna ARP (north reference), ACP (azimuth change) and TRIG (transmit trigger) inputs into the system clock domain and tracks the current azimuth count. It issues a request/acknowledge fetch of target data for each new azimuth and opens a fixed-length sweep window on every trigger. It also flags rotation and timing faults to the register block.

Parameters:
ACP_W, 12, width of azimuth counter and azimuth outputs
ACP_PER_REV, 4096, ACP pulses per antenna revolution (must be <= 2**ACP_W)
SWEEP_W, 16, width of sweep length and sweep counter
SYNC_STAGES, 2, synchroniser flops per async input (>= 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  controller enable, level, synchronous to clk
arp_in  in  1  async ARP pulse
acp_in  in  1  async ACP pulse
trig_in  in  1  async transmit trigger
sweep_len  in  SWEEP_W  sweep window length in clk cycles, sampled at sweep start
clr_err  in  1  one-cycle pulse, clears sticky flags
fetch_ack  in  1  fetch datapath accepts fetch_az
fetch_req  out  1  fetch request, held until acknowledged
fetch_az  out  ACP_W  azimuth to fetch
az_cnt  out  ACP_W  current azimuth count
synced  out  1  high once the first ARP has been seen since enable
sweep_start  out  1  one-cycle pulse at the start of a sweep window
sweep_active  out  1  high for the duration of the sweep window
sweep_az  out  ACP_W  az_cnt latched at sweep_start
arp_err  out  1  sticky: ARP arrived at a wrong ACP count
trig_miss  out  1  sticky: trigger arrived while a sweep was active
fetch_ovr  out  1  sticky: azimuth advanced while fetch_req was pending

Behaviour:
- Reset: all outputs 0; FSM in IDLE; synchroniser and history flops 0.
- Each async input passes through sig_sync_edge: SYNC_STAGES flops, then one history flop; rise = sync & ~hist. All controller outputs are registered. With SYNC_STAGES=2, the first clk edge that samples trig_in high gives sweep_start high in the cycle after the 4th edge. The same latency applies to ARP/ACP effects.
- FSM states:
  - IDLE: entered when en=0. Moves to WAIT_ARP when en=1.
  - WAIT_ARP: ACP and TRIG ignored. An ARP rise sets az_cnt=0, sets synced=1 and moves to RUN.
  - RUN: tracks azimuth and accepts triggers.
  - SWEEP: azimuth tracking continues. Returns to RUN when the sweep counter expires.
- en=0 in any state: move to IDLE next cycle, with synced=0, sweep_active=0, fetch_req=0 and az_cnt held. The sticky flags are not cleared.
- Azimuth tracking (RUN and SWEEP):
  - An ACP rise increments az_cnt, wrapping from ACP_PER_REV-1 to 0.
  - An ARP rise forces az_cnt=0. If az_cnt != ACP_PER_REV-1 at that moment, arp_err is set.
  - ARP and ACP rising in the same cycle: ARP wins (az_cnt=0), and the ACP is not counted.
- Fetch handshake:
  - Every az_cnt change in RUN/SWEEP (including the ARP reset to 0, and entry into RUN) loads fetch_az with the new az_cnt and sets fetch_req=1.
  - fetch_req clears in the cycle after fetch_ack=1 is sampled while fetch_req=1.
  - An az change while fetch_req=1 and fetch_ack=0: fetch_az takes the newest value, fetch_req stays 1 and fetch_ovr is set.
  - An az change in the same cycle as fetch_ack: the ack retires the old value, and a new request for the new value is raised with no gap and no overflow.
- Sweep:
  - A TRIG rise in RUN asserts sweep_start for 1 cycle and latches sweep_az=az_cnt. The counter loads max(sweep_len,1), and sweep_active=1 starting in the same cycle as sweep_start.
  - sweep_active stays high exactly max(sweep_len,1) cycles.
  - A TRIG rise in SWEEP sets trig_miss and is otherwise ignored.
  - A TRIG rise in the last active cycle is also a miss.
- clr_err clears arp_err, trig_miss and fetch_ovr. A set event in the same cycle wins over the clear.
- A reset asserted mid-sweep or mid-fetch drops everything immediately (asynchronously) to reset values.

Decomposition:
- Package radar_sync_pkg: FSM state enum (IDLE, WAIT_ARP, RUN, SWEEP) and the default ACP_PER_REV/ACP_W constants shared with the target-data fetch block.
- Sub-module sig_sync_edge (param SYNC_STAGES; ports clk, rst, async_sig, sync, rise, fall), instantiated three times.

Test Plan:
- ACP_PER_REV=8, SYNC_STAGES=2. en=1, ARP pulse, then 7 ACP pulses, then ARP. Required: az_cnt 0..7 then 0; arp_err=0; synced=1 at the 4th edge after ARP was first sampled.
- ARP after only 5 ACPs. Required: az_cnt goes 5→0 and arp_err=1. Then clr_err. Required: arp_err=0.
- ARP and ACP edges in the same clk sample. Required: az_cnt=0, no increment; fetch_req raised with fetch_az=0.
- fetch_ack held low across 2 ACPs, starting az_cnt=3. Required: fetch_az=5, fetch_ovr=1, fetch_req stays high. ack=1 for one cycle. Required: fetch_req drops next cycle.
- sweep_len=10, TRIG at az_cnt=4. Required: sweep_start is a single pulse, sweep_az=4, sweep_active high exactly 10 cycles. Second TRIG 3 cycles later. Required: trig_miss=1, window not extended.
- sweep_len=0. Required: sweep_active high 1 cycle. en dropped mid-sweep (sweep_len=20, drop at cycle 5). Required: sweep_active=0 and fetch_req=0 next cycle; rst pulse mid-sweep. Required: all outputs 0 immediately.
